spi_cmd_sequencer: RTL and testbench

Command front-end that sits directly upstream of the SPI master and drives its start_cmd/spi_drv_rdy command interface. The host pushes SPI commands (bit count and TX word) into a command FIFO over a valid/ready interface. The sequencer issues them one at a time to the SPI master, captures rx_miso on completion and returns it through a response FIFO. It also validates lengths, masks unused RX bits and flags a master that never acknowledges a command.

---
 rtl/spi_cmd_sequencer.sv | 148 ++++++++++++++
 tb/tb_spi_cmd_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer: queues SPI commands, issues them one at a time to the SPI master and returns masked MISO responses
module spi_cmd_sequencer #(
  parameter int SPI_MAXLEN = 32,
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int ACK_TIMEOUT = 1024,
  localparam int NW = $clog2(SPI_MAXLEN) + 1
) (
  input  logic                  clk,
  input  logic                  sresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [NW-1:0]         cmd_n_clks,
  input  logic [SPI_MAXLEN-1:0] cmd_tx_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [SPI_MAXLEN-1:0] rsp_data,
  output logic [NW-1:0]         rsp_n_clks,
  output logic                  rsp_err,
  output logic                  start_cmd,
  input  logic                  spi_drv_rdy,
  output logic [NW-1:0]         n_clks,
  output logic [SPI_MAXLEN-1:0] tx_data,
  input  logic [SPI_MAXLEN-1:0] rx_miso,
  output logic                  busy
);
  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int RAW = $clog2(RSP_DEPTH);
  localparam int CW = NW + SPI_MAXLEN;
  localparam int RW = SPI_MAXLEN + NW + 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, WRITE_RSP} state_t;
  state_t state;
  logic [CW-1:0] cmd_mem [CMD_DEPTH];
  logic [CAW-1:0] cmd_wp, cmd_rp;
  logic cmd_full, cmd_empty, cmd_push, cmd_pop;
  logic [RW-1:0] rsp_mem [RSP_DEPTH];
  logic [RAW-1:0] rsp_wp, rsp_rp;
  logic rsp_full, rsp_empty, rsp_push, rsp_pop;
  logic [NW-1:0] head_n;
  logic [SPI_MAXLEN-1:0] head_tx, cap_data, mask;
  logic cap_err;
  logic [TW-1:0] tcnt;

  assign {head_n, head_tx} = cmd_mem[cmd_rp];
  assign cmd_ready = ~cmd_full;
  assign cmd_push = cmd_valid & ~cmd_full;
  // IDLE only launches when the master is ready and the response slot is guaranteed
  assign cmd_pop = (state == IDLE) & ~cmd_empty & ~rsp_full & spi_drv_rdy;
  assign rsp_valid = ~rsp_empty;
  assign rsp_pop = rsp_valid & rsp_ready;
  assign rsp_push = state == WRITE_RSP;
  assign {rsp_data, rsp_n_clks, rsp_err} = rsp_mem[rsp_rp];
  // Inverted shift gives an all-ones mask for n == SPI_MAXLEN without overflow
  assign mask = ~({SPI_MAXLEN{1'b1}} << n_clks);
  assign busy = (state != IDLE) | ~cmd_empty;

  // Command storage, written on accepted host pushes
  always_ff @(posedge clk)
    if (cmd_push) cmd_mem[cmd_wp] <= {cmd_n_clks, cmd_tx_data};

  // Command FIFO pointers and registered full/empty flags
  always_ff @(posedge clk or negedge sresetn)
    if (!sresetn) begin
      cmd_wp <= '0;
      cmd_rp <= '0;
      cmd_empty <= 1'b1;
      cmd_full <= 1'b0;
    end else begin
      cmd_wp <= cmd_wp + CAW'(cmd_push);
      cmd_rp <= cmd_rp + CAW'(cmd_pop);
      if (cmd_push & ~cmd_pop) begin
        cmd_empty <= 1'b0;
        cmd_full <= (cmd_wp + CAW'(1)) == cmd_rp;
      end else if (cmd_pop & ~cmd_push) begin
        cmd_full <= 1'b0;
        cmd_empty <= (cmd_rp + CAW'(1)) == cmd_wp;
      end
    end

  // Response storage, written once per completed command
  always_ff @(posedge clk)
    if (rsp_push) rsp_mem[rsp_wp] <= {cap_data, n_clks, cap_err};

  // Response FIFO pointers and registered full/empty flags
  always_ff @(posedge clk or negedge sresetn)
    if (!sresetn) begin
      rsp_wp <= '0;
      rsp_rp <= '0;
      rsp_empty <= 1'b1;
      rsp_full <= 1'b0;
    end else begin
      rsp_wp <= rsp_wp + RAW'(rsp_push);
      rsp_rp <= rsp_rp + RAW'(rsp_pop);
      if (rsp_push & ~rsp_pop) begin
        rsp_empty <= 1'b0;
        rsp_full <= (rsp_wp + RAW'(1)) == rsp_rp;
      end else if (rsp_pop & ~rsp_push) begin
        rsp_full <= 1'b0;
        rsp_empty <= (rsp_rp + RAW'(1)) == rsp_wp;
      end
    end

  // Sequencer: launch, wait for ack (with timeout), wait for done, post response
  always_ff @(posedge clk or negedge sresetn)
    if (!sresetn) begin
      state <= IDLE;
      start_cmd <= 1'b0;
      n_clks <= '0;
      tx_data <= '0;
      cap_data <= '0;
      cap_err <= 1'b0;
      tcnt <= '0;
    end else
      case (state)
        IDLE:
          if (cmd_pop) begin
            n_clks <= head_n;
            tx_data <= head_tx;
            tcnt <= '0;
            if (head_n == '0 || head_n > NW'(SPI_MAXLEN)) begin
              cap_data <= '0;
              cap_err <= 1'b1;
              state <= WRITE_RSP;
            end else begin
              start_cmd <= 1'b1;
              state <= ISSUE;
            end
          end
        ISSUE:
          if (!spi_drv_rdy) begin
            start_cmd <= 1'b0;
            state <= WAIT_DONE;
          end else if (tcnt == TW'(ACK_TIMEOUT - 1)) begin
            start_cmd <= 1'b0;
            cap_data <= '0;
            cap_err <= 1'b1;
            state <= WRITE_RSP;
          end else tcnt <= tcnt + TW'(1);
        WAIT_DONE:
          if (spi_drv_rdy) begin
            cap_data <= rx_miso & mask;
            cap_err <= 1'b0;
            state <= WRITE_RSP;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// tb_spi_cmd_sequencer: directed self-checking bench with a behavioural SPI master model
module tb_spi_cmd_sequencer;
  localparam int ML = 32;
  localparam int NW = 6;
  logic clk = 1'b0;
  logic sresetn = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [NW-1:0] cmd_n_clks = '0;
  logic [ML-1:0] cmd_tx_data = '0;
  logic rsp_valid;
  logic rsp_ready = 1'b0;
  logic [ML-1:0] rsp_data;
  logic [NW-1:0] rsp_n_clks;
  logic rsp_err;
  logic start_cmd;
  logic spi_drv_rdy = 1'b1;
  logic [NW-1:0] n_clks;
  logic [ML-1:0] tx_data;
  logic [ML-1:0] rx_miso = '0;
  logic busy;
  int checks = 0;
  int fails = 0;
  int pulses = 0;
  int run = 0;
  int last_len = 0;
  int unstable = 0;
  logic [NW-1:0] p_n;
  logic [ML-1:0] p_tx;
  bit ack_en = 1'b1;
  bit inv_mode = 1'b0;
  logic [ML-1:0] miso_val = '0;
  logic [ML-1:0] m_tx;

  spi_cmd_sequencer #(.SPI_MAXLEN(ML), .CMD_DEPTH(4), .RSP_DEPTH(4), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .sresetn(sresetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_n_clks(cmd_n_clks), .cmd_tx_data(cmd_tx_data), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_n_clks(rsp_n_clks), .rsp_err(rsp_err),
    .start_cmd(start_cmd), .spi_drv_rdy(spi_drv_rdy), .n_clks(n_clks), .tx_data(tx_data),
    .rx_miso(rx_miso), .busy(busy)
  );

  always #5 clk = ~clk;

  // start_cmd pulse counter, pulse length and command-stability monitor
  always @(negedge clk) begin
    if (start_cmd) begin
      run <= run + 1;
      if (run == 0) begin
        pulses <= pulses + 1;
        p_n <= n_clks;
        p_tx <= tx_data;
      end else if (n_clks !== p_n || tx_data !== p_tx) unstable <= unstable + 1;
    end else if (run != 0) begin
      last_len <= run;
      run <= 0;
    end
  end

  // SPI master model: ack one cycle after seeing start_cmd, done four cycles later
  initial forever begin
    @(negedge clk);
    if (sresetn && ack_en && start_cmd && spi_drv_rdy) begin
      m_tx = tx_data;
      @(posedge clk);
      #1 spi_drv_rdy = 1'b0;
      repeat (4) @(posedge clk);
      #1 rx_miso = inv_mode ? ~m_tx : miso_val;
      spi_drv_rdy = 1'b1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic push(input logic [NW-1:0] n, input logic [ML-1:0] tx);
    int w = 0;
    cmd_n_clks = n;
    cmd_tx_data = tx;
    do begin
      @(negedge clk);
      w++;
    end while (!cmd_ready && w < 200);
    if (!cmd_ready) begin
      checks++;
      fails++;
      $display("FAIL push_wait: cmd_ready=%b required 1 within 200 cycles", cmd_ready);
    end else begin
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic pop(output logic [ML-1:0] d, output logic [NW-1:0] n, output logic e);
    int w = 0;
    @(negedge clk);
    while (!rsp_valid && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!rsp_valid) begin
      checks++;
      fails++;
      $display("FAIL pop_wait: rsp_valid=%b required 1 within 300 cycles", rsp_valid);
      d = 'x;
      n = 'x;
      e = 1'bx;
    end else begin
      d = rsp_data;
      n = rsp_n_clks;
      e = rsp_err;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (start_cmd !== 1'b0) begin fails++; $display("FAIL rst_start: got %b required 0", start_cmd); end
    checks++; if (n_clks !== '0) begin fails++; $display("FAIL rst_n_clks: got %0d required 0", n_clks); end
    checks++; if (tx_data !== '0) begin fails++; $display("FAIL rst_tx_data: got %h required 0", tx_data); end
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_rsp_valid: got %b required 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b required 0", busy); end
    sresetn = 1'b1;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rst_cmd_ready: got %b required 1", cmd_ready); end
  endtask

  task automatic test_single();
    logic [ML-1:0] d;
    logic [NW-1:0] n;
    logic e;
    int p0 = pulses;
    int u0 = unstable;
    inv_mode = 1'b0;
    miso_val = 32'h3C;
    push(6'd8, 32'hA5);
    checks++; if (start_cmd !== 1'b0) begin fails++; $display("FAIL single_start_early: got %b required 0", start_cmd); end
    @(negedge clk);
    checks++; if (start_cmd !== 1'b1) begin fails++; $display("FAIL single_start_latency: got %b required 1", start_cmd); end
    checks++; if (n_clks !== 6'd8) begin fails++; $display("FAIL single_n_clks: got %0d required 8", n_clks); end
    checks++; if (tx_data !== 32'hA5) begin fails++; $display("FAIL single_tx_data: got %h required a5", tx_data); end
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy: got %b required 1", busy); end
    pop(d, n, e);
    checks++; if (d !== 32'h3C) begin fails++; $display("FAIL single_data: got %h required 3c", d); end
    checks++; if (n !== 6'd8) begin fails++; $display("FAIL single_n: got %0d required 8", n); end
    checks++; if (e !== 1'b0) begin fails++; $display("FAIL single_err: got %b required 0", e); end
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL single_one_rsp: rsp_valid=%b required 0", rsp_valid); end
    checks++; if (last_len !== 2) begin fails++; $display("FAIL single_pulse_len: got %0d required 2", last_len); end
    checks++; if (pulses - p0 !== 1) begin fails++; $display("FAIL single_pulses: got %0d required 1", pulses - p0); end
    checks++; if (unstable !== u0) begin fails++; $display("FAIL single_stable: %0d changes while start_cmd high, required 0", unstable - u0); end
  endtask

  task automatic test_full_len();
    logic [ML-1:0] d;
    logic [NW-1:0] n;
    logic e;
    inv_mode = 1'b0;
    miso_val = 32'hFFFF_FFFF;
    push(6'd32, 32'hDEAD_BEEF);
    pop(d, n, e);
    checks++; if (d !== 32'hFFFF_FFFF) begin fails++; $display("FAIL full_data: got %h required ffffffff", d); end
    checks++; if (n !== 6'd32) begin fails++; $display("FAIL full_n: got %0d required 32", n); end
    checks++; if (e !== 1'b0) begin fails++; $display("FAIL full_err: got %b required 0", e); end
    push(6'd5, 32'h0);
    pop(d, n, e);
    checks++; if (d !== 32'h1F) begin fails++; $display("FAIL mask5_data: got %h required 1f", d); end
    checks++; if (n !== 6'd5) begin fails++; $display("FAIL mask5_n: got %0d required 5", n); end
  endtask

  task automatic test_len_err();
    logic [ML-1:0] d;
    logic [NW-1:0] n;
    logic e;
    int p0 = pulses;
    miso_val = 32'h1234_5678;
    push(6'd0, 32'h1234);
    push(6'd33, 32'h5678);
    pop(d, n, e);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL len0_data: got %h required 0", d); end
    checks++; if (n !== 6'd0) begin fails++; $display("FAIL len0_n: got %0d required 0", n); end
    checks++; if (e !== 1'b1) begin fails++; $display("FAIL len0_err: got %b required 1", e); end
    pop(d, n, e);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL len33_data: got %h required 0", d); end
    checks++; if (n !== 6'd33) begin fails++; $display("FAIL len33_n: got %0d required 33", n); end
    checks++; if (e !== 1'b1) begin fails++; $display("FAIL len33_err: got %b required 1", e); end
    checks++; if (pulses !== p0) begin fails++; $display("FAIL len_err_no_start: got %0d pulses required 0", pulses - p0); end
  endtask

  task automatic test_backpressure();
    logic [NW-1:0] bn [8] = '{6'd4, 6'd8, 6'd12, 6'd16, 6'd1, 6'd2, 6'd3, 6'd20};
    logic [ML-1:0] btx [8] = '{32'h0000_000A, 32'h0000_0012, 32'h0000_0ABC, 32'h0000_1234,
                               32'h0, 32'h1, 32'h7, 32'h000F_0000};
    logic [ML-1:0] bexp [8] = '{32'h5, 32'hED, 32'h543, 32'hEDCB, 32'h1, 32'h2, 32'h0, 32'h0_FFFF};
    logic [ML-1:0] d;
    logic [NW-1:0] n;
    logic e;
    int p0 = pulses;
    inv_mode = 1'b1;
    for (int i = 0; i < 8; i++) push(bn[i], btx[i]);
    repeat (40) @(negedge clk);
    checks++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL bp_cmd_ready: got %b required 0", cmd_ready); end
    checks++; if (pulses - p0 !== 4) begin fails++; $display("FAIL bp_stall: got %0d issued required 4", pulses - p0); end
    checks++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL bp_rsp_valid: got %b required 1", rsp_valid); end
    for (int i = 0; i < 8; i++) begin
      pop(d, n, e);
      checks++; if (d !== bexp[i]) begin fails++; $display("FAIL bp_data[%0d]: got %h required %h", i, d, bexp[i]); end
      checks++; if (n !== bn[i]) begin fails++; $display("FAIL bp_n[%0d]: got %0d required %0d", i, n, bn[i]); end
      checks++; if (e !== 1'b0) begin fails++; $display("FAIL bp_err[%0d]: got %b required 0", i, e); end
    end
    checks++; if (pulses - p0 !== 8) begin fails++; $display("FAIL bp_total: got %0d issued required 8", pulses - p0); end
    inv_mode = 1'b0;
  endtask

  task automatic test_timeout();
    logic [ML-1:0] d;
    logic [NW-1:0] n;
    logic e;
    ack_en = 1'b0;
    push(6'd8, 32'h55);
    pop(d, n, e);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL to_data: got %h required 0", d); end
    checks++; if (n !== 6'd8) begin fails++; $display("FAIL to_n: got %0d required 8", n); end
    checks++; if (e !== 1'b1) begin fails++; $display("FAIL to_err: got %b required 1", e); end
    checks++; if (last_len !== 16) begin fails++; $display("FAIL to_pulse_len: got %0d required 16", last_len); end
    ack_en = 1'b1;
    miso_val = 32'h81;
    push(6'd8, 32'h33);
    pop(d, n, e);
    checks++; if (d !== 32'h81) begin fails++; $display("FAIL to_next_data: got %h required 81", d); end
    checks++; if (e !== 1'b0) begin fails++; $display("FAIL to_next_err: got %b required 0", e); end
  endtask

  task automatic test_reset_mid();
    logic [ML-1:0] d;
    logic [NW-1:0] n;
    logic e;
    int w = 0;
    int p0 = pulses;
    miso_val = 32'hABCD;
    push(6'd16, 32'h1111);
    while (!(pulses > p0 && !start_cmd && !spi_drv_rdy) && w < 50) begin
      @(negedge clk);
      w++;
    end
    checks++; if (spi_drv_rdy !== 1'b0) begin fails++; $display("FAIL mid_reach_wait: spi_drv_rdy=%b required 0", spi_drv_rdy); end
    sresetn = 1'b0;
    #1;
    checks++; if (start_cmd !== 1'b0) begin fails++; $display("FAIL mid_start: got %b required 0", start_cmd); end
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL mid_rsp_valid: got %b required 0", rsp_valid); end
    checks++; if (n_clks !== '0) begin fails++; $display("FAIL mid_n_clks: got %0d required 0", n_clks); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy: got %b required 0", busy); end
    repeat (10) @(negedge clk);
    sresetn = 1'b1;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL mid_cmd_ready: got %b required 1", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL mid_rsp_lost: got %b required 0", rsp_valid); end
    miso_val = 32'hFFFF_F5A5;
    push(6'd12, 32'h0FFF);
    pop(d, n, e);
    checks++; if (d !== 32'h5A5) begin fails++; $display("FAIL mid_fresh_data: got %h required 5a5", d); end
    checks++; if (n !== 6'd12) begin fails++; $display("FAIL mid_fresh_n: got %0d required 12", n); end
    checks++; if (e !== 1'b0) begin fails++; $display("FAIL mid_fresh_err: got %b required 0", e); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_len();
    test_len_err();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
